// File: rtl/dac7821_pkg.sv
// Shared types and constants for the DAC7821 parallel-bus master.
// Holds the data width, the phase-counter width and the bus-cycle state enum.
package dac7821_pkg;

  localparam int DAC_W = 12;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_SETUP,
    R_STROBE,
    R_HOLD
  } state_t;

endpackage

// File: rtl/dac7821_phase_cnt.sv
// Loadable 4-bit down-counter with a zero flag, reused for every bus phase.
// Ports: clk, rst (async high), load, load_val (N-1 of the phase), zero.
module dac7821_phase_cnt
  import dac7821_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dac7821_bus_if.sv
// DAC7821 parallel-bus master: one 12-bit sample per valid/ready handshake,
// driven as a CS_n/RW_n/DB write cycle with counted setup, strobe and hold.
// Ports: Clock, Reset (async high), Din/Valid/Ready handshake, DAC_CS_n,
// DAC_RW_n, DAC_DB_o/DAC_DB_oe/DAC_DB_i pads, Busy, Rb_Data, Rb_Err.
// Macro DAC7821_READBACK_EN adds a read-back cycle and sticky compare.
module dac7821_bus_if
  import dac7821_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [DAC_W-1:0] Din,
  input  logic             Valid,
  output logic             Ready,
  output logic             DAC_CS_n,
  output logic             DAC_RW_n,
  output logic [DAC_W-1:0] DAC_DB_o,
  output logic             DAC_DB_oe,
  input  logic [DAC_W-1:0] DAC_DB_i,
  output logic             Busy,
  output logic [DAC_W-1:0] Rb_Data,
  output logic             Rb_Err
);

  localparam logic [CNT_W-1:0] S_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] P_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] H_LD = CNT_W'(HOLD_CYC - 1);

  state_t           state;
  logic             zero;
  logic             cnt_ld;
  logic [CNT_W-1:0] cnt_val;

  dac7821_phase_cnt u_cnt (
    .clk      (Clock),
    .rst      (Reset),
    .load     (cnt_ld),
    .load_val (cnt_val),
    .zero     (zero)
  );

  // Reload the counter with the length of the phase being entered.
  always_comb begin
    cnt_ld  = 1'b0;
    cnt_val = '0;
    unique case (state)
      IDLE: begin
        cnt_ld  = Valid;
        cnt_val = S_LD;
      end
      W_SETUP: begin
        cnt_ld  = zero;
        cnt_val = P_LD;
      end
      W_STROBE: begin
        cnt_ld  = zero;
        cnt_val = H_LD;
      end
`ifdef DAC7821_READBACK_EN
      W_HOLD: begin
        cnt_ld  = zero;
        cnt_val = S_LD;
      end
      R_SETUP: begin
        cnt_ld  = zero;
        cnt_val = P_LD;
      end
      R_STROBE: begin
        cnt_ld  = zero;
        cnt_val = H_LD;
      end
`endif
      default: begin
        cnt_ld  = 1'b0;
        cnt_val = '0;
      end
    endcase
  end

  // DAC_DB_o doubles as the holding register for the accepted word.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Ready     <= 1'b1;
      Busy      <= 1'b0;
      DAC_CS_n  <= 1'b1;
      DAC_RW_n  <= 1'b1;
      DAC_DB_o  <= '0;
      DAC_DB_oe <= 1'b0;
`ifdef DAC7821_READBACK_EN
      Rb_Data   <= '0;
      Rb_Err    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (Valid) begin
          state     <= W_SETUP;
          Ready     <= 1'b0;
          Busy      <= 1'b1;
          DAC_DB_o  <= Din;
          DAC_DB_oe <= 1'b1;
          DAC_RW_n  <= 1'b0;
        end
        W_SETUP: if (zero) begin
          state    <= W_STROBE;
          DAC_CS_n <= 1'b0;
        end
        W_STROBE: if (zero) begin
          state    <= W_HOLD;
          DAC_CS_n <= 1'b1;
        end
        W_HOLD: if (zero) begin
          DAC_DB_oe <= 1'b0;
          DAC_RW_n  <= 1'b1;
`ifdef DAC7821_READBACK_EN
          state     <= R_SETUP;
`else
          state     <= IDLE;
          Ready     <= 1'b1;
          Busy      <= 1'b0;
`endif
        end
`ifdef DAC7821_READBACK_EN
        R_SETUP: if (zero) begin
          state    <= R_STROBE;
          DAC_CS_n <= 1'b0;
        end
        R_STROBE: if (zero) begin
          state    <= R_HOLD;
          DAC_CS_n <= 1'b1;
          Rb_Data  <= DAC_DB_i;
        end
        R_HOLD: begin
          if (Rb_Data != DAC_DB_o) Rb_Err <= 1'b1;
          if (zero) begin
            state <= IDLE;
            Ready <= 1'b1;
            Busy  <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DAC7821_READBACK_EN
  logic unused_db;
  assign unused_db = ^DAC_DB_i;
  assign Rb_Data   = '0;
  assign Rb_Err    = 1'b0;
`endif

endmodule

// File: doc/dac7821_bus_if.md
# dac7821_bus_if

Parallel-bus master for the DAC7821 12-bit multiplying DAC, sitting between the modulation-waveform sample register and the DAC pins. It accepts one 12-bit sample per valid/ready handshake and generates the CS_n / RW_n / DB write cycle with cycle-counted setup, strobe and hold phases. Optionally, it follows every write with a read-back cycle and flags any mismatch for the waveform controller.

## Interface
- SETUP_CYC, 2: cycles DB/RW_n are stable before CS_n falls; legal range 1..15
- PULSE_CYC, 3: CS_n low width in cycles; legal range 1..15
- HOLD_CYC, 2: cycles DB/RW_n are held after CS_n rises; legal range 1..15
- Clock  in  1  system clock; every register updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- Din  in  12  sample to write
- Valid  in  1  Din is valid
- Ready  out  1  block is idle and accepts Din
- DAC_CS_n  out  1  DAC chip select, active low
- DAC_RW_n  out  1  0 = write, 1 = read
- DAC_DB_o  out  12  data driven to the DAC
- DAC_DB_oe  out  1  pad output enable for DB
- DAC_DB_i  in  12  data read from the pads
- Busy  out  1  a bus cycle is in progress (equal to ~Ready)
- Rb_Data  out  12  last read-back word
- Rb_Err  out  1  sticky read-back mismatch flag

## Operation
- All outputs are registered.
- Reset values:
  - Ready=1, Busy=0
  - DAC_CS_n=1, DAC_RW_n=1
  - DAC_DB_o=0, DAC_DB_oe=0
  - Rb_Data=0, Rb_Err=0
  - state=IDLE, phase counter=0
- **IDLE**: Ready=1, CS_n=1, RW_n=1, DB_oe=0. When Valid=1 the block latches Din into a holding register and moves to W_SETUP.
- **W_SETUP** (SETUP_CYC cycles): DB_oe=1, DB_o=held word, RW_n=0, CS_n=1.
- **W_STROBE** (PULSE_CYC cycles): CS_n=0; DB, RW_n and DB_oe unchanged.
- **W_HOLD** (HOLD_CYC cycles): CS_n=1; DB_oe, DB_o and RW_n stay at their write values.
  - Without the read-back feature: next state is IDLE.
  - With the read-back feature: next state is R_SETUP.
- **R_SETUP** (SETUP_CYC cycles): DB_oe=0, RW_n=1, CS_n=1.
- **R_STROBE** (PULSE_CYC cycles): CS_n=0. DAC_DB_i is captured into Rb_Data on the last strobe cycle.
- **R_HOLD** (HOLD_CYC cycles): CS_n=1.
  - Compare Rb_Data with the held word; set Rb_Err if they differ.
  - Next state is IDLE.
- Phase counter:
  - 4 bits, loaded with N-1 on entry to each phase.
  - The phase exits when the counter reads 0.
  - No wrap-around is possible within the legal parameter range.
- Rb_Err is cleared only by Reset. It is never cleared by a later matching read.
- Valid is ignored outside IDLE. The held word is never modified mid-cycle.

## Timing
- Handshake: a transfer occurs on an edge where Valid=1 and Ready=1. Ready falls on that same edge and rises on the edge that returns the block to IDLE.
- Write-only throughput: one word per SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles. The extra cycle is the IDLE cycle.
- The first W_SETUP cycle is the cycle after acceptance.
- With defaults, CS_n is low in cycles 3..5 after acceptance (counting the acceptance edge as cycle 0).
- Read-back adds SETUP_CYC+PULSE_CYC+HOLD_CYC cycles per word.
- Bus turnaround:
  - DB_oe and RW_n never change in the same cycle that CS_n is 0.
  - DB_oe drops on entry to R_SETUP, not before.
- Valid held high continuously: the next word is accepted in the first IDLE cycle.
- Reset asserted mid-cycle: all outputs go to their reset values immediately (asynchronously). CS_n goes high even during a strobe. No partial cycle resumes after reset.

## Configuration
- Macro: DAC7821_READBACK_EN.
- Defined: the R_SETUP / R_STROBE / R_HOLD states and the compare logic are built. Rb_Data and Rb_Err are live.
- Undefined: the read states are removed. Rb_Data is tied to 0 and Rb_Err to 0. DAC_DB_i is unused.

## Structure
- Shared package dac7821_pkg holds:
  - DAC_W=12
  - the state enum (IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD)
  - the phase-counter width constant (4)
- Natural sub-module: dac7821_phase_cnt. It is a loadable down-counter with a zero flag, reused for all three phase lengths.

## Test plan
- **Single write, defaults, no read-back**: Din=0xA5C with Valid for one cycle.
  - CS_n is low exactly 3 cycles.
  - DB_o=0xA5C and RW_n=0 for 7 cycles.
  - Ready returns 8 cycles after acceptance.
- **Back-to-back**: Valid held high with Din=0x001, 0x002, 0x003.
  - Three CS_n pulses appear with 0x001, 0x002, 0x003 in order.
  - No word is dropped; the pulses are spaced 8 cycles apart.
- **Parameter corners**: SETUP=PULSE=HOLD=1; write 0xFFF.
  - The CS_n low pulse is 1 cycle.
  - Setup and hold are each 1 cycle, measured with a bus monitor.
- **Read-back match (DAC7821_READBACK_EN)**: the bench model returns the written word 0x3C3.
  - Rb_Data=0x3C3 and Rb_Err=0.
  - DB_oe is 0 throughout the read strobe.
- **Read-back mismatch (DAC7821_READBACK_EN)**: write 0x800, model returns 0x801.
  - Rb_Err=1 and stays 1 after a subsequent matching write.
- **Reset mid-strobe**: assert Reset during the second cycle of W_STROBE.
  - CS_n=1, DB_oe=0 and Ready=1 immediately.
  - After release, the next accepted word 0x123 is written cleanly.
